// File: rtl/uart_rx_buffer_pkg.sv
// Shared UART receive-side types and defaults used by the RX character buffer.
// Holds the buffer entry type, the default buffer depth and the controller strobe bundle.
package uart_rx_buffer_pkg;

  localparam int RX_DATA_WIDTH = 8;
  localparam int RX_BUF_DEPTH  = 8;

  typedef struct packed {
    logic [RX_DATA_WIDTH-1:0] data;
    logic                     frame_err;
  } rx_entry_t;

  // Strobes issued by the RX controller; rx_buf_wr drives the buffer's wr_en.
  typedef struct packed {
    logic rx_sample;
    logic rx_shift;
    logic rx_buf_wr;
  } controlPoints_t;

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Storage for the RX buffer: DEPTH entries, one write port, one registered read port.
// The read register forwards a same-cycle write to the addressed slot so a new head is never stale.
module uart_rx_fifo_mem
  import uart_rx_buffer_pkg::*;
#(
  parameter int  DEPTH   = RX_BUF_DEPTH,
  parameter type entry_t = rx_entry_t,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  entry_t        wdata,
  input  logic [AW-1:0] raddr,
  output entry_t        rdata
);

  entry_t mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rdata <= '0;
    end else if (we && (waddr == raddr)) begin
      rdata <= wdata;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/uart_rx_buffer.sv
// First-word-fall-through receive character buffer with a sticky overrun flag.
// Define UART_RX_FRAME_ERR_EN to store and present the per-character framing-error tag.
module uart_rx_buffer
  import uart_rx_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = RX_DATA_WIDTH,
  parameter int DEPTH      = RX_BUF_DEPTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     wr_frame_err,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     rd_frame_err,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overrun,
  input  logic                     overrun_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  frame_err;
  } entry_t;

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_addr;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_next;
  logic          rd_valid_q;
  logic          full_q;
  logic          overrun_q;
  logic          push;
  logic          pop;
  logic          drop;
  entry_t        wr_entry;
  entry_t        head;

  // A full buffer still accepts a write when the head leaves in the same cycle.
  always_comb begin
    pop        = rd_valid_q && rd_ready;
    push       = wr_en && (!full_q || pop);
    drop       = wr_en && full_q && !pop;
    count_next = count_q;
    if (push && !pop) begin
      count_next = count_q + 1'b1;
    end else if (pop && !push) begin
      count_next = count_q - 1'b1;
    end
    rd_addr = pop ? rd_ptr + 1'b1 : rd_ptr;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      full_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count_q    <= count_next;
      rd_valid_q <= (count_next != '0);
      full_q     <= (count_next == CW'(DEPTH));
      if (drop) begin
        overrun_q <= 1'b1;
      end else if (overrun_clr) begin
        overrun_q <= 1'b0;
      end
    end
  end

  uart_rx_fifo_mem #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_mem (
    .clock (clock),
    .reset (reset),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_addr),
    .rdata (head)
  );

  assign wr_entry.data = wr_data;
  assign rd_data       = head.data;

`ifdef UART_RX_FRAME_ERR_EN
  assign wr_entry.frame_err = wr_frame_err;
  assign rd_frame_err       = head.frame_err;
`else
  logic unused_frame_err;
  assign wr_entry.frame_err = 1'b0;
  assign rd_frame_err       = 1'b0;
  assign unused_frame_err   = wr_frame_err ^ head.frame_err;
`endif

  assign rd_valid = rd_valid_q;
  assign count    = count_q;
  assign full     = full_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Directed self-checking bench for uart_rx_buffer (DATA_WIDTH=8, DEPTH=8).
// Inputs change 1 time unit after a rising edge; outputs are checked in the same window.
module tb_uart_rx_buffer;

  logic       clock = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       wr_frame_err;
  logic       rd_valid;
  logic       rd_ready;
  logic [7:0] rd_data;
  logic       rd_frame_err;
  logic [3:0] count;
  logic       full;
  logic       overrun;
  logic       overrun_clr;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef UART_RX_FRAME_ERR_EN
  localparam logic EXP_FE = 1'b1;
`else
  localparam logic EXP_FE = 1'b0;
`endif

  always #5 clock = ~clock;

  uart_rx_buffer #(
    .DATA_WIDTH (8),
    .DEPTH      (8)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .wr_frame_err (wr_frame_err),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_data      (rd_data),
    .rd_frame_err (rd_frame_err),
    .count        (count),
    .full         (full),
    .overrun      (overrun),
    .overrun_clr  (overrun_clr)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic push_only(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic pulse_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; wr_en = 1'b0; wr_data = '0; wr_frame_err = 1'b0;
    rd_ready = 1'b0; overrun_clr = 1'b0;
    tick(); tick();
    reset = 1'b0;
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    n_checks++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
    n_checks++; if (rd_frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_rd_frame_err: got %b want 0", rd_frame_err); end
  endtask

  task automatic test_single_push;
    wr_en = 1'b1; wr_data = 8'h55;
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL push_same_cycle_valid: got %b want 0", rd_valid); end
    tick();
    wr_en = 1'b0;
    n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL push_next_valid: got %b want 1", rd_valid); end
    n_checks++; if (rd_data !== 8'h55) begin n_fail++; $display("FAIL push_next_data: got %h want 55", rd_data); end
    n_checks++; if (count !== 4'd1) begin n_fail++; $display("FAIL push_count: got %0d want 1", count); end
    rd_ready = 1'b1;
    tick();
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL pop_valid: got %b want 0", rd_valid); end
    tick();
    rd_ready = 1'b0;
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL pop_empty_count: got %0d want 0", count); end
  endtask

  task automatic test_fill_overrun;
    for (int i = 1; i <= 8; i++) push_only(8'(i));
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %b want 1", full); end
    n_checks++; if (count !== 4'd8) begin n_fail++; $display("FAIL fill_count: got %0d want 8", count); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL fill_no_overrun: got %b want 0", overrun); end
    push_only(8'hAA);
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL drop_overrun: got %b want 1", overrun); end
    n_checks++; if (count !== 4'd8) begin n_fail++; $display("FAIL drop_count: got %0d want 8", count); end
    rd_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      n_checks++; if (rd_valid !== 1'b1 || rd_data !== 8'(i)) begin n_fail++; $display("FAIL drain_data: got valid=%b data=%h want valid=1 data=%h", rd_valid, rd_data, 8'(i)); end
      tick();
    end
    rd_ready = 1'b0;
    n_checks++; if (rd_valid !== 1'b0 || count !== 4'd0 || full !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got valid=%b count=%0d full=%b want 0/0/0", rd_valid, count, full); end
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_clear: got %b want 0", overrun); end
  endtask

  task automatic test_full_push_pop;
    logic [7:0] exp_q [$];
    for (int i = 0; i < 8; i++) push_only(8'h10 + 8'(i));
    wr_en = 1'b1; wr_data = 8'h99; rd_ready = 1'b1;
    tick();
    wr_en = 1'b0;
    n_checks++; if (count !== 4'd8 || full !== 1'b1) begin n_fail++; $display("FAIL full_pushpop_count: got count=%0d full=%b want 8/1", count, full); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL full_pushpop_overrun: got %b want 0", overrun); end
    for (int i = 1; i < 8; i++) exp_q.push_back(8'h10 + 8'(i));
    exp_q.push_back(8'h99);
    foreach (exp_q[i]) begin
      n_checks++; if (rd_valid !== 1'b1 || rd_data !== exp_q[i]) begin n_fail++; $display("FAIL full_pushpop_order: got valid=%b data=%h want valid=1 data=%h", rd_valid, rd_data, exp_q[i]); end
      tick();
    end
    rd_ready = 1'b0;
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL full_pushpop_drain: got %0d want 0", count); end
  endtask

  task automatic test_overrun_clr_race;
    for (int i = 0; i < 8; i++) push_only(8'h20 + 8'(i));
    push_only(8'hAB);
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL race_first_drop: got %b want 1", overrun); end
    wr_en = 1'b1; wr_data = 8'hCD; overrun_clr = 1'b1;
    tick();
    wr_en = 1'b0;
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL race_set_wins: got %b want 1", overrun); end
    tick();
    overrun_clr = 1'b0;
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL race_lone_clear: got %b want 0", overrun); end
    n_checks++; if (rd_data !== 8'h20 || count !== 4'd8) begin n_fail++; $display("FAIL race_storage: got data=%h count=%0d want 20/8", rd_data, count); end
    pulse_reset();
  endtask

  task automatic test_frame_err;
    wr_frame_err = 1'b1;
    push_only(8'h3C);
    wr_frame_err = 1'b0;
    n_checks++; if (rd_data !== 8'h3C) begin n_fail++; $display("FAIL fe_data: got %h want 3c", rd_data); end
    n_checks++; if (rd_frame_err !== EXP_FE) begin n_fail++; $display("FAIL fe_tag: got %b want %b", rd_frame_err, EXP_FE); end
    wr_en = 1'b1; wr_data = 8'h3D; rd_ready = 1'b1;
    tick();
    wr_en = 1'b0;
    n_checks++; if (rd_data !== 8'h3D || rd_frame_err !== 1'b0 || count !== 4'd1) begin n_fail++; $display("FAIL fe_clean_next: got data=%h fe=%b count=%0d want 3d/0/1", rd_data, rd_frame_err, count); end
    tick();
    rd_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 5; i++) push_only(8'h40 + 8'(i));
    n_checks++; if (count !== 4'd5) begin n_fail++; $display("FAIL mid_pre_count: got %0d want 5", count); end
    reset = 1'b1; wr_en = 1'b1; wr_data = 8'hEE; rd_ready = 1'b1; overrun_clr = 1'b1;
    tick();
    reset = 1'b0; wr_en = 1'b0; rd_ready = 1'b0; overrun_clr = 1'b0;
    n_checks++; if (count !== 4'd0 || rd_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset: got count=%0d valid=%b want 0/0", count, rd_valid); end
    n_checks++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL mid_reset_data: got %h want 00", rd_data); end
    push_only(8'h77);
    n_checks++; if (rd_data !== 8'h77 || count !== 4'd1) begin n_fail++; $display("FAIL mid_first_write: got data=%h count=%0d want 77/1", rd_data, count); end
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [7:0] q [$];
    for (int i = 0; i < 4; i++) begin
      push_only(8'hA0 + 8'(i));
      q.push_back(8'hA0 + 8'(i));
    end
    for (int c = 0; c < 20; c++) begin
      n_checks++; if (rd_valid !== 1'b1 || rd_data !== q[0]) begin n_fail++; $display("FAIL wrap_data: cycle %0d got valid=%b data=%h want valid=1 data=%h", c, rd_valid, rd_data, q[0]); end
      wr_en = 1'b1; wr_data = 8'hB0 + 8'(c); rd_ready = 1'b1;
      tick();
      void'(q.pop_front());
      q.push_back(8'hB0 + 8'(c));
      n_checks++; if (count !== 4'd4) begin n_fail++; $display("FAIL wrap_count: cycle %0d got %0d want 4", c, count); end
    end
    wr_en = 1'b0;
    while (q.size() > 0) begin
      n_checks++; if (rd_valid !== 1'b1 || rd_data !== q[0]) begin n_fail++; $display("FAIL wrap_drain: got valid=%b data=%h want valid=1 data=%h", rd_valid, rd_data, q[0]); end
      tick();
      void'(q.pop_front());
    end
    rd_ready = 1'b0;
    n_checks++; if (rd_valid !== 1'b0 || count !== 4'd0) begin n_fail++; $display("FAIL wrap_empty: got valid=%b count=%0d want 0/0", rd_valid, count); end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_fill_overrun();
    test_full_push_pop();
    test_overrun_clr_race();
    test_frame_err();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
